// File: rtl/elink_test_sequencer.sv
// Sequences the eLink self-test engines: INIT, then GOLD->ELINK2 and ELINK2->GOLD (serially or
// concurrently), with a per-phase watchdog and a held pass/fail verdict.
module elink_test_sequencer #(
    parameter bit          CONCURRENT     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       aclk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] done,
    input  logic [2:0] error,
    output logic [2:0] run,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [2:0] fail_code,
    output logic       timeout,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_G2E  = 3'd2,
        S_E2G  = 3'd3,
        S_BOTH = 3'd4,
        S_PASS = 3'd5,
        S_FAIL = 3'd6
    } state_t;

    localparam int unsigned    WD_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state, w_state_d;
    logic            r_start_q;
    logic            r_start_armed;
    logic [WD_W-1:0] r_wdog, w_wdog_d;
    logic [1:0]      r_latch, w_latch_d;
    logic [2:0]      r_fail_code, w_fail_code_d;
    logic            r_timeout, w_timeout_d;
    logic [2:0]      r_run;

    logic            w_start_rise;
    logic            w_active;
    logic [2:0]      w_run_mask;
    logic [2:0]      w_err;
    logic            w_phase_done;
    logic            w_wd_expired;

    function automatic logic [2:0] run_of(input state_t s);
        case (s)
            S_INIT:  return 3'b100;
            S_G2E:   return 3'b001;
            S_E2G:   return 3'b010;
            S_BOTH:  return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Armed only once start has been seen low, so a start held through reset is not an edge.
    assign w_start_rise = start & ~r_start_q & r_start_armed;
    assign w_active     = (r_state == S_INIT) || (r_state == S_G2E) ||
                          (r_state == S_E2G)  || (r_state == S_BOTH);
    assign w_run_mask   = run_of(r_state);
    assign w_err        = error & w_run_mask;
    assign w_wd_expired = (r_wdog == WD_MAX);

    always_comb begin
        w_phase_done = 1'b0;
        case (r_state)
            S_INIT:  w_phase_done = done[2];
            S_G2E:   w_phase_done = done[0];
            S_E2G:   w_phase_done = done[1];
            S_BOTH:  w_phase_done = &(r_latch | done[1:0]);
            default: w_phase_done = 1'b0;
        endcase
    end

    always_comb begin
        w_state_d     = r_state;
        w_wdog_d      = r_wdog;
        w_latch_d     = r_latch;
        w_fail_code_d = r_fail_code;
        w_timeout_d   = r_timeout;

        if (w_active) begin
            w_wdog_d = r_wdog + WD_W'(1);
            if (r_state == S_BOTH) begin
                w_latch_d = r_latch | done[1:0];
            end
            // Priority: error, then completion, then watchdog expiry.
            if (|w_err) begin
                w_state_d     = S_FAIL;
                w_fail_code_d = w_err;
                w_timeout_d   = 1'b0;
            end else if (w_phase_done) begin
                case (r_state)
                    S_INIT:  w_state_d = CONCURRENT ? S_BOTH : S_G2E;
                    S_G2E:   w_state_d = S_E2G;
                    default: w_state_d = S_PASS;
                endcase
            end else if (w_wd_expired) begin
                w_state_d     = S_FAIL;
                w_fail_code_d = 3'b000;
                w_timeout_d   = 1'b1;
            end
        end else if (w_start_rise) begin
            w_state_d     = S_INIT;
            w_fail_code_d = 3'b000;
            w_timeout_d   = 1'b0;
        end

        if (w_state_d != r_state) begin
            w_wdog_d  = '0;
            w_latch_d = '0;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_start_q     <= 1'b0;
            r_start_armed <= 1'b0;
            r_wdog        <= '0;
            r_latch       <= '0;
            r_fail_code   <= '0;
            r_timeout     <= 1'b0;
            r_run         <= '0;
        end else begin
            r_state       <= w_state_d;
            r_start_q     <= start;
            r_start_armed <= r_start_armed | ~start;
            r_wdog        <= w_wdog_d;
            r_latch       <= w_latch_d;
            r_fail_code   <= w_fail_code_d;
            r_timeout     <= w_timeout_d;
            r_run         <= run_of(w_state_d);
        end
    end

    assign run       = r_run;
    assign busy      = w_active;
    assign pass      = (r_state == S_PASS);
    assign fail      = (r_state == S_FAIL);
    assign fail_code = r_fail_code;
    assign timeout   = r_timeout;
    assign phase     = r_state;

endmodule

// File: tb/tb_elink_test_sequencer.sv
// Randomised and directed check of elink_test_sequencer in serial (index 0) and concurrent
// (index 1) configurations against a per-phase outcome model.
module tb_elink_test_sequencer;

    localparam int unsigned T0  = 16;
    localparam int unsigned T1  = 40;
    localparam int          BIG = 1 << 30;

    logic       aclk = 1'b0;
    logic       reset;
    logic       start_v   [2];
    logic [2:0] done_v    [2];
    logic [2:0] error_v   [2];
    logic [2:0] run_v     [2];
    logic       busy_v    [2];
    logic       pass_v    [2];
    logic       fail_v    [2];
    logic [2:0] fc_v      [2];
    logic       to_v      [2];
    logic [2:0] ph_v      [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Per phase code (1..4) and engine: cycle index of done / error pulse, -1 = never.
    int dd_tab [5][3];
    int de_tab [5][3];

    always #5 aclk = ~aclk;

    elink_test_sequencer #(.CONCURRENT(1'b0), .TIMEOUT_CYCLES(T0)) u_seq (
        .aclk(aclk), .reset(reset), .start(start_v[0]), .done(done_v[0]), .error(error_v[0]),
        .run(run_v[0]), .busy(busy_v[0]), .pass(pass_v[0]), .fail(fail_v[0]),
        .fail_code(fc_v[0]), .timeout(to_v[0]), .phase(ph_v[0])
    );

    elink_test_sequencer #(.CONCURRENT(1'b1), .TIMEOUT_CYCLES(T1)) u_conc (
        .aclk(aclk), .reset(reset), .start(start_v[1]), .done(done_v[1]), .error(error_v[1]),
        .run(run_v[1]), .busy(busy_v[1]), .pass(pass_v[1]), .fail(fail_v[1]),
        .fail_code(fc_v[1]), .timeout(to_v[1]), .phase(ph_v[1])
    );

    function automatic logic [2:0] exp_run(input int ph);
        case (ph)
            1:       return 3'b100;
            2:       return 3'b001;
            3:       return 3'b010;
            4:       return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_state(input int sel, input string tag, input int ph,
                             input logic [2:0] fc, input logic to);
        chk({tag, ".phase"}, 32'(ph_v[sel]), 32'(ph));
        chk({tag, ".run"},   32'(run_v[sel]), 32'(exp_run(ph)));
        chk({tag, ".busy"},  32'(busy_v[sel]), 32'(ph >= 1 && ph <= 4));
        chk({tag, ".pass"},  32'(pass_v[sel]), 32'(ph == 5));
        chk({tag, ".fail"},  32'(fail_v[sel]), 32'(ph == 6));
        chk({tag, ".fcode"}, 32'(fc_v[sel]), 32'(fc));
        chk({tag, ".tmo"},   32'(to_v[sel]), 32'(to));
    endtask

    task automatic clear_tab();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 3; i++) begin
                dd_tab[p][i] = -1;
                de_tab[p][i] = -1;
            end
        end
    endtask

    // Outcome of one phase is the earliest of: any running engine's error, the last running
    // engine's done, or the watchdog at cycle T-1; ties resolve error > done > watchdog.
    task automatic do_phase(input int sel, input int ph, output bit ok,
                            output logic [2:0] fc, output logic to);
        int         tmo, emin, dc, x;
        bit         dnever;
        logic [2:0] runm;
        tmo    = (sel == 0) ? int'(T0) : int'(T1);
        runm   = exp_run(ph);
        emin   = BIG;
        dc     = -1;
        dnever = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (runm[i]) begin
                if (de_tab[ph][i] >= 0 && de_tab[ph][i] < emin) emin = de_tab[ph][i];
                if (dd_tab[ph][i] < 0) dnever = 1'b1;
                else if (dd_tab[ph][i] > dc) dc = dd_tab[ph][i];
            end
        end
        if (dnever) dc = BIG;
        x = tmo - 1;
        if (dc < x) x = dc;
        if (emin < x) x = emin;
        fc = 3'b000;
        to = 1'b0;
        if (emin == x) begin
            ok = 1'b0;
            for (int i = 0; i < 3; i++) if (runm[i] && de_tab[ph][i] == x) fc[i] = 1'b1;
        end else if (dc == x) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
            to = 1'b1;
        end
        for (int j = 0; j <= x; j++) begin
            chk_state(sel, "active", ph, 3'b000, 1'b0);
            for (int i = 0; i < 3; i++) begin
                done_v[sel][i]  = runm[i] ? (dd_tab[ph][i] == j) : ($urandom_range(0, 3) == 0);
                error_v[sel][i] = runm[i] ? (de_tab[ph][i] == j) : ($urandom_range(0, 4) == 0);
            end
            start_v[sel] = 1'($urandom_range(0, 1));
            tick();
        end
        done_v[sel]  = 3'b000;
        error_v[sel] = 3'b000;
        start_v[sel] = 1'b0;
    endtask

    task automatic run_phases(input int sel);
        int         cur, fin_ph;
        bit         ok, fin;
        logic [2:0] fc;
        logic       to;
        cur = 1;
        fin = 1'b0;
        fin_ph = 5;
        fc = 3'b000;
        to = 1'b0;
        while (!fin) begin
            do_phase(sel, cur, ok, fc, to);
            if (!ok) begin
                fin_ph = 6;
                fin = 1'b1;
            end else if (cur == 1) begin
                cur = (sel == 0) ? 2 : 4;
            end else if (cur == 2) begin
                cur = 3;
            end else begin
                fin_ph = 5;
                fin = 1'b1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk_state(sel, "verdict", fin_ph, fc, to);
            tick();
        end
    endtask

    task automatic run_seq(input int sel);
        start_v[sel] = 1'b1;
        tick();
        run_phases(sel);
    endtask

    task automatic gen_phase(input int ph, input int tmo);
        logic [2:0] runm;
        int         r, first;
        runm  = exp_run(ph);
        r     = $urandom_range(0, 9);
        first = runm[0] ? 0 : (runm[1] ? 1 : 2);
        for (int i = 0; i < 3; i++) begin
            dd_tab[ph][i] = runm[i] ? $urandom_range(0, tmo - 3) : -1;
            de_tab[ph][i] = -1;
        end
        if (r == 6) begin
            de_tab[ph][first] = $urandom_range(0, tmo - 1);
        end else if (r == 7) begin
            de_tab[ph][runm[1] ? 1 : first] = $urandom_range(0, tmo - 1);
            if (runm[0]) de_tab[ph][0] = $urandom_range(0, tmo - 1);
        end else if (r == 8) begin
            dd_tab[ph][first] = -1;
        end else if (r == 9) begin
            dd_tab[ph][first] = tmo - 1;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start_v[s] = 1'b0;
            done_v[s]  = 3'b000;
            error_v[s] = 3'b000;
        end
        repeat (3) tick();
        chk_state(0, "reset0", 0, 3'b000, 1'b0);
        chk_state(1, "reset1", 0, 3'b000, 1'b0);
        @(negedge aclk);
        reset = 1'b0;
        repeat (2) tick();
        chk_state(0, "idle0", 0, 3'b000, 1'b0);

        // Serial clean run: INIT -> G2E -> E2G -> PASS.
        clear_tab();
        dd_tab[1][2] = 3;
        dd_tab[2][0] = 5;
        dd_tab[3][1] = 2;
        run_seq(0);

        // Concurrent: done[0] 20 cycles before done[1].
        clear_tab();
        dd_tab[1][2] = 1;
        dd_tab[4][0] = 4;
        dd_tab[4][1] = 24;
        run_seq(1);

        // Error in G2E without done.
        clear_tab();
        dd_tab[1][2] = 0;
        de_tab[2][0] = 3;
        run_seq(0);

        // INIT never completes -> watchdog, then a fresh start clears and restarts.
        clear_tab();
        run_seq(0);
        dd_tab[1][2] = 2;
        dd_tab[2][0] = 1;
        dd_tab[3][1] = 1;
        run_seq(0);

        // Completion coincides with expiry in E2G, then error coincides with expiry.
        clear_tab();
        dd_tab[1][2] = 0;
        dd_tab[2][0] = 0;
        dd_tab[3][1] = T0 - 1;
        run_seq(0);
        dd_tab[3][1] = T0 - 1;
        de_tab[3][1] = T0 - 1;
        run_seq(0);

        // Simultaneous errors in BOTH.
        clear_tab();
        dd_tab[1][2] = 0;
        dd_tab[4][0] = 2;
        dd_tab[4][1] = 20;
        de_tab[4][0] = 7;
        de_tab[4][1] = 7;
        run_seq(1);

        // Reset during E2G with start held high.
        start_v[0] = 1'b1;
        tick();
        chk_state(0, "rst.init", 1, 3'b000, 1'b0);
        start_v[0] = 1'b0;
        done_v[0] = 3'b100;
        tick();
        done_v[0] = 3'b001;
        tick();
        done_v[0] = 3'b000;
        start_v[0] = 1'b1;
        chk_state(0, "rst.e2g", 3, 3'b000, 1'b0);
        #2 reset = 1'b1;
        #1 chk_state(0, "rst.async", 0, 3'b000, 1'b0);
        @(negedge aclk);
        reset = 1'b0;
        repeat (3) begin
            tick();
            chk_state(0, "rst.held", 0, 3'b000, 1'b0);
        end
        start_v[0] = 1'b0;
        tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        clear_tab();
        dd_tab[1][2] = 1;
        dd_tab[2][0] = 2;
        dd_tab[3][1] = 3;
        run_phases(0);

        // Randomised sequences on both configurations.
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = n % 2;
            clear_tab();
            for (int p = 1; p <= 4; p++) gen_phase(p, (sel == 0) ? int'(T0) : int'(T1));
            run_seq(sel);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elink_test_sequencer.md
ELINK_TEST_SEQUENCER -- requirements
Module: elink_test_sequencer

Interface
REQ-001 SHALL have parameters: CONCURRENT, 0, 1 runs GOLD->ELINK2 and ELINK2->GOLD engines together after INIT; TIMEOUT_CYCLES, 100000, per-phase watchdog limit (>=2).
REQ-002 SHALL have ports, one clock and asynchronous active-high reset: aclk in 1 clock; reset in 1 async active-high reset.
REQ-003 start in 1: sequence request, rising-edge sensitive.
REQ-004 done in 3: engine complete; bit0 GOLD->ELINK2, bit1 ELINK2->GOLD, bit2 INIT.
REQ-005 error in 3: engine error flags, same bit mapping as done.
REQ-006 run out 3: engine enable levels, same bit mapping.
REQ-007 busy out 1: sequence in progress.
REQ-008 pass out 1, fail out 1: final verdict, held.
REQ-009 fail_code out 3: engine(s) whose error caused fail.
REQ-010 timeout out 1: fail caused by watchdog.
REQ-011 phase out 3: state encoding IDLE=0, INIT=1, G2E=2, E2G=3, BOTH=4, PASS=5, FAIL=6.

Function
REQ-012 start SHALL be registered; rising edge = start high while previous sample low.
REQ-013 In IDLE, PASS or FAIL, a start rising edge SHALL clear pass/fail/fail_code/timeout/watchdog and enter INIT next cycle.
REQ-014 A start rising edge while busy SHALL be ignored.
REQ-015 run[2] SHALL be high exactly in INIT; run[0] in G2E or BOTH; run[1] in E2G or BOTH; all registered, low elsewhere.
REQ-016 busy SHALL be high in INIT, G2E, E2G, BOTH.
REQ-017 INIT: done[2]=1 and error[2]=0 -> G2E (CONCURRENT=0) or BOTH (CONCURRENT=1).
REQ-018 G2E: done[0]=1, error[0]=0 -> E2G; E2G: done[1]=1, error[1]=0 -> PASS.
REQ-019 BOTH: per-engine done bits SHALL be latched; when both latched and no error -> PASS; latches cleared on BOTH entry.
REQ-020 In any active phase, error[i]=1 for an engine running in that phase SHALL enter FAIL next cycle with fail_code[i]=1, whether or not done[i] is set; errors of non-running engines ignored.
REQ-021 In BOTH, simultaneous errors SHALL set all corresponding fail_code bits.
REQ-022 Watchdog counter SHALL clear on every phase entry, increment each active-phase cycle, and on reaching TIMEOUT_CYCLES-1 without phase exit enter FAIL with timeout=1, fail_code=0.
REQ-023 Completion (done) and watchdog expiry in same cycle: completion wins; error and watchdog same cycle: error wins, timeout=0.
REQ-024 pass=1 exactly in PASS; fail=1 exactly in FAIL; fail_code/timeout valid while fail=1, zero otherwise.
REQ-025 Phase transition latency: state change on the aclk edge after the qualifying done/error sample; run changes the same edge.

Reset
REQ-026 reset SHALL asynchronously force IDLE, run=0, busy=0, pass=0, fail=0, fail_code=0, timeout=0, watchdog=0, start history=0, BOTH latches=0.
REQ-027 reset asserted mid-sequence SHALL abort immediately; after release, a new start rising edge is required (start held high through release is not an edge).

Verification
REQ-028 CONCURRENT=0, start 0->1, engines finish clean -> run=100, 001, 010 in turn; phase 1,2,3,5; pass=1, fail_code=000.
REQ-029 CONCURRENT=1, done[0] 20 cycles before done[1], no errors -> run=011 in BOTH, PASS one cycle after done[1].
REQ-030 error[0] pulsed in G2E with done[0]=0 -> FAIL next cycle, fail_code=001, timeout=0, run=000.
REQ-031 TIMEOUT_CYCLES=16, INIT never done -> FAIL after 16 INIT cycles, timeout=1, fail_code=000; second start edge restarts from INIT with outputs cleared.
REQ-032 reset asserted during E2G with start held high -> outputs zero immediately, stays IDLE after release until start toggles low then high.
REQ-033 done[1] and watchdog expiry same cycle in E2G -> PASS; error[1] and expiry same cycle -> FAIL, fail_code=010, timeout=0.
